// File: rtl/writeback_pkg.sv
// Shared constants and types for the writeback stage: opcode and funct3 codes,
// exception causes, datapath widths and the load-align response struct.
package writeback_pkg;

  localparam int WB_XLEN       = 32;
  localparam int WB_REG_ADDR_W = 5;
  localparam int WB_EX_W       = 4;
  localparam int WB_CNT_W      = 64;

  localparam logic [4:0] OP_LOAD = 5'b00000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [WB_EX_W-1:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [WB_EX_W-1:0] CAUSE_LD_MISALIGN = 4'd4;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} wb_state_e;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic               misaligned;
    logic               illegal;
  } align_rsp_t;

endpackage

// File: rtl/writeback_load_align.sv
// Combinational load alignment: picks the byte/half/word out of a little-endian
// dmem word, sign/zero-extends it, and flags misaligned or undefined sizes.
module writeback_load_align
  import writeback_pkg::*;
(
  input  logic [2:0]         funct,
  input  logic [1:0]         addr_lo,
  input  logic [WB_XLEN-1:0] word,
  output align_rsp_t         rsp
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // select lane by address, then extend according to funct3
  always_comb begin
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    rsp    = '0;
    case (funct)
      F3_LB:  rsp.data = {{(WB_XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: rsp.data = {{(WB_XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        rsp.data       = {{(WB_XLEN-16){half_v[15]}}, half_v};
        rsp.misaligned = addr_lo[0];
      end
      F3_LHU: begin
        rsp.data       = {{(WB_XLEN-16){1'b0}}, half_v};
        rsp.misaligned = addr_lo[0];
      end
      F3_LW: begin
        rsp.data       = word;
        rsp.misaligned = (addr_lo != 2'b00);
      end
      default: rsp.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: register-file write with load alignment, bypass data,
// retire counter, and conversion of exceptions into a held trap + flush.
module writeback
  import writeback_pkg::*;
#(
  parameter int CNT_W = WB_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipeline_in_valid,
  input  logic                     nop_instr_in,
  input  logic [4:0]               opcode_in,
  input  logic [2:0]               funct_in,
  input  logic [1:0]               addr_lo_in,
  input  logic [WB_XLEN-1:0]       result_in,
  input  logic [WB_REG_ADDR_W-1:0] rd_addr_in,
  input  logic [WB_EX_W-1:0]       exception_in,
  input  logic                     exception_in_valid,
  input  logic                     stall_in,
  input  logic                     trap_ack,
  output logic                     rf_wr_enable,
  output logic [WB_REG_ADDR_W-1:0] rf_wr_addr,
  output logic [WB_XLEN-1:0]       rf_wr_data,
  output logic                     trap_req,
  output logic [WB_EX_W-1:0]       trap_cause,
  output logic                     flush_out,
  output logic                     stall_out,
  output logic [CNT_W-1:0]         instret
);

  wb_state_e           state_q, state_d;
  align_rsp_t          ld;
  logic                is_load, accept, exc, retire, wr, ack;
  logic [WB_EX_W-1:0]  cause;

  writeback_load_align u_load_align (
    .funct   (funct_in),
    .addr_lo (addr_lo_in),
    .word    (result_in),
    .rsp     (ld)
  );

  // accept/exception decode; upstream cause wins over locally detected ones
  always_comb begin
    is_load = (opcode_in == OP_LOAD);
    accept  = (state_q == RUN) && pipeline_in_valid && !stall_in;
    exc     = 1'b1;
    cause   = exception_in;
    if (exception_in_valid)           cause = exception_in;
    else if (is_load && ld.illegal)    cause = CAUSE_ILLEGAL;
    else if (is_load && ld.misaligned) cause = CAUSE_LD_MISALIGN;
    else begin
      exc   = 1'b0;
      cause = '0;
    end
    retire = accept && !nop_instr_in && !exc;
    wr     = retire && (rd_addr_in != '0);
    // a stalled stage is frozen, so an ack seen under stall is not taken
    ack    = (state_q == TRAP) && trap_ack && !stall_in;
  end

  // next state: trap on an accepted exception, leave TRAP on ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && exc) state_d = TRAP;
      TRAP:    if (ack)           state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // write port, retire counter and trap request
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_enable <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      trap_req     <= 1'b0;
      trap_cause   <= '0;
      instret      <= '0;
    end else begin
      rf_wr_enable <= wr;
      if (retire) begin
        rf_wr_addr <= rd_addr_in;
        rf_wr_data <= is_load ? ld.data : result_in;
        instret    <= instret + CNT_W'(1);
      end
      if (accept && exc) begin
        trap_req   <= 1'b1;
        trap_cause <= cause;
      end else if (ack) begin
        trap_req   <= 1'b0;
      end
    end
  end

  // flush comes straight from the state register; stall also reflects stall_in
  assign flush_out = (state_q == TRAP);
  assign stall_out = (state_q == TRAP) || stall_in;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios then random stimulus,
// all compared against a transaction-level reference model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset, pipeline_in_valid, nop_instr_in;
  logic [4:0]  opcode_in;
  logic [2:0]  funct_in;
  logic [1:0]  addr_lo_in;
  logic [31:0] result_in;
  logic [4:0]  rd_addr_in;
  logic [3:0]  exception_in;
  logic        exception_in_valid, stall_in, trap_ack;

  logic        rf_wr_enable, trap_req, flush_out, stall_out;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [3:0]  trap_cause;
  logic [63:0] instret;

  logic        s_we, s_trap_req, s_flush, s_stall;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_cause;
  logic [3:0]  s_instret;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [4:0] OPC_LOAD = 5'b00000;
  localparam logic [4:0] OPC_ALU  = 5'b01100;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .reset(reset), .pipeline_in_valid(pipeline_in_valid),
    .nop_instr_in(nop_instr_in), .opcode_in(opcode_in), .funct_in(funct_in),
    .addr_lo_in(addr_lo_in), .result_in(result_in), .rd_addr_in(rd_addr_in),
    .exception_in(exception_in), .exception_in_valid(exception_in_valid),
    .stall_in(stall_in), .trap_ack(trap_ack),
    .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .trap_req(trap_req), .trap_cause(trap_cause), .flush_out(flush_out),
    .stall_out(stall_out), .instret(instret)
  );

  // narrow-counter instance on the same stimulus to exercise counter wrap
  writeback #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .pipeline_in_valid(pipeline_in_valid),
    .nop_instr_in(nop_instr_in), .opcode_in(opcode_in), .funct_in(funct_in),
    .addr_lo_in(addr_lo_in), .result_in(result_in), .rd_addr_in(rd_addr_in),
    .exception_in(exception_in), .exception_in_valid(exception_in_valid),
    .stall_in(stall_in), .trap_ack(trap_ack),
    .rf_wr_enable(s_we), .rf_wr_addr(s_addr), .rf_wr_data(s_data),
    .trap_req(s_trap_req), .trap_cause(s_cause), .flush_out(s_flush),
    .stall_out(s_stall), .instret(s_instret)
  );

  // reference model state
  bit          m_trap, m_we;
  logic [3:0]  m_cause;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [63:0] m_cnt;
  int          wraps_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [2:0] f, input logic [1:0] off,
                                              input logic [31:0] w);
    int unsigned b = (w >> (8 * off)) & 32'hFF;
    int unsigned h = (w >> (16 * off[1])) & 32'hFFFF;
    int v;
    case (f)
      3'b000:  begin v = int'(b); if (v >= 128) v -= 256; return 32'(v); end
      3'b001:  begin v = int'(h); if (v >= 32768) v -= 65536; return 32'(v); end
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  // cause the instruction would raise, or -1 if none
  function automatic int model_cause();
    int size;
    if (exception_in_valid) return int'(exception_in);
    if (opcode_in != OPC_LOAD) return -1;
    case (funct_in)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        return 2;
    endcase
    if (int'(addr_lo_in) % size != 0) return 4;
    return -1;
  endfunction

  task automatic model_next();
    int c;
    m_we = 1'b0;
    if (reset) begin
      m_trap = 0; m_cause = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    end else if (stall_in) begin
      // frozen
    end else if (m_trap) begin
      if (trap_ack) m_trap = 0;
    end else if (pipeline_in_valid) begin
      c = model_cause();
      if (c >= 0) begin
        m_trap = 1; m_cause = 4'(c);
      end else if (!nop_instr_in) begin
        m_cnt = m_cnt + 1;
        if (m_cnt[3:0] == 4'd0) wraps_seen++;
        m_data = (opcode_in == OPC_LOAD) ? load_value(funct_in, addr_lo_in, result_in)
                                         : result_in;
        m_addr = rd_addr_in;
        m_we   = (rd_addr_in != 0);
      end
    end
  endtask

  task automatic check_all();
    chk("wr_enable", rf_wr_enable, m_we);
    if (m_we) begin
      chk("wr_addr", rf_wr_addr, m_addr);
      chk("wr_data", rf_wr_data, m_data);
    end
    chk("trap_req", trap_req, m_trap);
    chk("trap_cause", trap_cause, m_cause);
    chk("flush_out", flush_out, m_trap);
    chk("stall_out", stall_out, m_trap | stall_in);
    chk("instret", instret, m_cnt);
    chk("instret_narrow", s_instret, m_cnt[3:0]);
    chk("narrow_we", s_we, m_we);
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drv(input bit v, input bit n, input logic [4:0] op, input logic [2:0] f,
                     input logic [1:0] a, input logic [31:0] r, input logic [4:0] rd);
    pipeline_in_valid = v; nop_instr_in = n; opcode_in = op; funct_in = f;
    addr_lo_in = a; result_in = r; rd_addr_in = rd;
  endtask

  task automatic idle();
    drv(0, 0, OPC_ALU, 3'b000, 2'b00, 32'h0, 5'd0);
    exception_in_valid = 0; exception_in = 0; stall_in = 0; trap_ack = 0;
  endtask

  logic [2:0]  ld_f   [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]  ld_off [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
  logic [31:0] ld_exp [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                              32'hFFFF_80FF, 32'h0000_7F01};

  initial begin
    reset = 1; idle();
    step(); step();
    chk("rst_wr_addr", rf_wr_addr, 5'd0);
    chk("rst_wr_data", rf_wr_data, 32'd0);
    reset = 0;

    // ALU retire
    drv(1, 0, OPC_ALU, 3'b000, 2'b00, 32'h0000_1234, 5'd5); step();
    chk("alu_data", rf_wr_data, 32'h0000_1234);
    chk("alu_instret", instret, 64'd1);

    // load alignment of 0x80FF_7F01, back-to-back
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, OPC_LOAD, ld_f[i], ld_off[i], 32'h80FF_7F01, 5'(i + 1)); step();
      chk("load_data", rf_wr_data, ld_exp[i]);
    end

    // rd=x0 retires without writing; nop neither writes nor retires
    drv(1, 0, OPC_ALU, 3'b000, 2'b00, 32'hDEAD_BEEF, 5'd0); step();
    chk("x0_instret", instret, 64'd7);
    drv(1, 1, OPC_ALU, 3'b000, 2'b00, 32'hDEAD_BEEF, 5'd9); step();
    chk("nop_instret", instret, 64'd7);

    // misaligned LW -> trap, ack after 3 cycles, next instruction accepted
    drv(1, 0, OPC_LOAD, 3'b010, 2'd2, 32'h1111_2222, 5'd3); step();
    chk("mis_cause", trap_cause, 4'd4);
    drv(1, 0, OPC_ALU, 3'b000, 2'b00, 32'h5555, 5'd6); step(); step();
    trap_ack = 1; step();
    trap_ack = 0; step();
    chk("post_ack_we", rf_wr_enable, 1'b1);
    chk("post_ack_trap", trap_req, 1'b0);

    // upstream cause 2 wins over misaligned load; ack in the rising cycle
    drv(1, 0, OPC_LOAD, 3'b001, 2'd1, 32'h0, 5'd4);
    exception_in_valid = 1; exception_in = 4'd2; step();
    chk("prio_cause", trap_cause, 4'd2);
    exception_in_valid = 0; trap_ack = 1; idle(); trap_ack = 1; step();
    trap_ack = 0;

    // stall_in for two cycles mid-stream
    drv(1, 0, OPC_ALU, 3'b000, 2'b00, 32'hA0A0, 5'd7); step();
    drv(1, 0, OPC_ALU, 3'b000, 2'b00, 32'hB0B0, 5'd8); stall_in = 1; step();
    chk("stall_instret", instret, 64'd9);
    step();
    stall_in = 0; step();
    chk("unstall_data", rf_wr_data, 32'hB0B0);
    idle(); step();

    // reset while in TRAP dominates stall_in and trap_ack
    drv(1, 0, OPC_LOAD, 3'b111, 2'd0, 32'h0, 5'd1); step();
    reset = 1; stall_in = 1; trap_ack = 1; step();
    chk("rst_trap", trap_req, 1'b0);
    chk("rst_instret", instret, 64'd0);
    reset = 0; idle(); step();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      reset              = ($urandom_range(0, 199) == 0);
      pipeline_in_valid  = ($urandom_range(0, 9) < 8);
      nop_instr_in       = ($urandom_range(0, 9) == 0);
      opcode_in          = ($urandom_range(0, 1) == 0) ? OPC_LOAD : OPC_ALU;
      funct_in           = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b010;
      if ($urandom_range(0, 1) == 0) funct_in = ld_f[$urandom_range(0, 4)];
      addr_lo_in         = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      result_in          = $urandom;
      rd_addr_in         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      exception_in_valid = ($urandom_range(0, 29) == 0);
      exception_in       = 4'($urandom);
      stall_in           = ($urandom_range(0, 9) == 0);
      trap_ack           = ($urandom_range(0, 2) == 0);
      step();
    end
    chk("wrap_seen", 64'(wraps_seen > 0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Final (fifth) stage of the in-order pipeline; consumes the registered output of the memory stage. Aligns and sign/zero-extends load data, writes the register file, provides the bypass source for decode/execute, counts retired instructions and converts pipeline exceptions into a held trap request with a pipeline flush. One clock, one instruction per cycle.

## Interface
- XLEN, 32, register/data width
- REG_ADDR_W, 5, register index width
- EX_W, 4, exception cause width
- CNT_W, 64, retire counter width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pipeline_in_valid  in  1  memory stage holds a valid instruction
- nop_instr_in  in  1  bubble/NOP; never writes, never retires
- opcode_in  in  5  instr[6:2]; OP_LOAD selects alignment path
- funct_in  in  3  funct3 (load size/sign)
- addr_lo_in  in  2  low bits of the load address
- result_in  in  XLEN  ALU result or raw 32-bit dmem word
- rd_addr_in  in  REG_ADDR_W  destination register
- exception_in  in  EX_W  upstream cause
- exception_in_valid  in  1  upstream exception present
- stall_in  in  1  global hold; stage state frozen
- trap_ack  in  1  trap unit has taken the trap
- rf_wr_enable  out  1  register file write strobe
- rf_wr_addr  out  REG_ADDR_W  write index
- rf_wr_data  out  XLEN  write data (also bypass data)
- trap_req  out  1  trap pending, held until trap_ack
- trap_cause  out  EX_W  cause of pending trap
- flush_out  out  1  flush all upstream stages
- stall_out  out  1  stage cannot accept
- instret  out  CNT_W  retired-instruction count

## Operation
- States: RUN, TRAP. Reset -> RUN.
- Accept = RUN & pipeline_in_valid & !stall_in. stall_in freezes state, counter and all outputs except rf_wr_enable, which drops to 0.
- Non-load accept: rf_wr_data <= result_in, rf_wr_addr <= rd_addr_in.
- Load alignment (funct): 000 LB sign-ext byte[addr_lo]; 001 LH sign-ext half[addr_lo[1]]; 010 LW word; 100 LBU; 101 LHU zero-ext. Bytes little-endian.
- Local exceptions on loads: LH/LHU with addr_lo[0]=1 or LW with addr_lo!=0 -> cause 4 (load misaligned); funct 011/110/111 -> cause 2 (illegal). Upstream exception_in_valid takes priority over local.
- Exception on accept: no register write, no retire, trap_cause <= cause, trap_req <= 1, state -> TRAP.
- Write enable: accept & !nop & no exception & rd_addr_in!=0. rd=x0 still retires.
- instret += 1 on every accept with !nop & no exception; wraps 2^CNT_W-1 -> 0.
- TRAP: flush_out=1, stall_out=1, inputs ignored. trap_ack -> trap_req <= 0, state -> RUN. trap_ack in RUN ignored.
- stall_out = (state==TRAP) | stall_in combinationally; otherwise 0.

## Timing
- Reset values: rf_wr_enable 0, rf_wr_addr 0, rf_wr_data 0, trap_req 0, trap_cause 0, flush_out 0, stall_out 0 (unless stall_in), instret 0.
- Latency: accept in cycle N -> rf_wr_enable high for exactly cycle N+1 (one-cycle pulse per instruction); back-to-back accepts give continuous strobes.
- Exception accepted cycle N -> trap_req, flush_out high from N+1; trap_ack sampled at cycle M -> trap_req, flush_out low from M+1; first new accept at M+1.
- trap_ack in the same cycle trap_req rises is valid (minimum TRAP residency one cycle).
- reset mid-TRAP: back to RUN, trap_req 0 next cycle; reset dominates stall_in and trap_ack.
- flush_out is registered (from state), never combinational from inputs.

## Structure
- Opcodes (OP_LOAD), funct3 load codes, cause codes (2 illegal, 4 load misaligned) and width defines live in the shared def_params header; no local literals.
- One combinational sub-module load_align: (funct, addr_lo, word) -> (data, misaligned, illegal); reused by any future LR/AMO path.

## Test plan
- ALU retire: result_in=0x0000_1234, rd=5, valid -> next cycle rf_wr_enable=1, addr 5, data 0x0000_1234; instret 0->1.
- Loads of word 0x80FF_7F01: LB off1 -> 0x0000_007F; LB off2 -> 0xFFFF_FFFF; LBU off3 -> 0x0000_0080; LH off2 -> 0xFFFF_80FF; LHU off0 -> 0x0000_7F01.
- rd=x0 and nop: rd=0 -> no write, instret+1; nop -> no write, instret unchanged.
- Misaligned LW off2 -> no write, trap_req=1 cause 4, flush_out=1, stall_out=1 until trap_ack; trap_ack 3 cycles later -> all clear next cycle, next instruction accepted.
- Upstream exception cause 2 together with misaligned load -> trap_cause=2; stall_in high 2 cycles mid-stream -> outputs and instret frozen, no duplicate write.
- instret preset near 2^64-1 via 2 retires from forced value -> wraps to 0; reset asserted in TRAP -> trap_req 0, instret 0 next cycle.
